// File: rtl/bitmode_pixel_rmw.sv
// rtl/bitmode_pixel_rmw.sv - CPU bitmode 4bpp pixel read / read-modify-write engine on shared video RAM
//
// Ports:
//   clk, reset_n        system clock, asynchronous active-low reset
//   ce2Hd               2H clock-enable qualifying request capture
//   bm_req, bm_rwn      access strobe and direction (1=read, 0=write)
//   bm_wdata            CPU write data, only [3:0] is the pixel value
//   drba, pixa          pixel byte address and nibble select (0=[7:4], 1=[3:0])
//   vid_slot            video owns the RAM this cycle; no strobes allowed
//   vram_addr/re/we/d   RAM request side; vram_q is the read data
//   bm_rdata            last read result, held until the next read completes
//   busy, done, overrun access in progress, completion pulse, sticky overrun
//
// Build option: BITMODE_READ_DUP_EN - reads return the nibble in both halves.

module bitmode_pixel_rmw #(
    parameter int RD_LAT = 1,
    parameter int AW     = 15
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          ce2Hd,
    input  logic          bm_req,
    input  logic          bm_rwn,
    input  logic [7:0]    bm_wdata,
    input  logic [AW-1:0] drba,
    input  logic          pixa,
    input  logic          vid_slot,
    output logic [AW-1:0] vram_addr,
    output logic          vram_re,
    output logic          vram_we,
    output logic [7:0]    vram_d,
    input  logic [7:0]    vram_q,
    output logic [7:0]    bm_rdata,
    output logic          busy,
    output logic          done,
    output logic          overrun
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_WAIT,
        S_MERGE,
        S_WR,
        S_DONE
    } state_t;

    localparam logic [2:0] LAT_LAST = 3'(RD_LAT - 1);

    state_t        r_state;
    state_t        w_next;
    logic [AW-1:0] r_addr;
    logic          r_pix;
    logic          r_rwn;
    logic [3:0]    r_wnib;
    logic [7:0]    r_q;
    logic [7:0]    r_wbyte;
    logic [2:0]    r_lat_cnt;
    logic          r_busy;
    logic          r_overrun;
    logic [7:0]    r_rdata;

    logic          w_req;
    logic          w_lat_last;
    logic [3:0]    w_nib;
    logic [7:0]    w_rdata;
    logic          w_unused;

    assign w_req      = bm_req & ce2Hd;
    assign w_lat_last = (r_lat_cnt == LAT_LAST);
    // Selected nibble straight off the RAM bus, valid on the last WAIT cycle.
    assign w_nib      = r_pix ? vram_q[3:0] : vram_q[7:4];
    assign w_unused   = ^bm_wdata[7:4];

`ifdef BITMODE_READ_DUP_EN
    assign w_rdata = {w_nib, w_nib};
`else
    assign w_rdata = {4'h0, w_nib};
`endif

    always_comb begin
        w_next    = r_state;
        vram_re   = 1'b0;
        vram_we   = 1'b0;
        vram_addr = '0;
        vram_d    = 8'h00;
        done      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_req) w_next = S_RD;
            end
            S_RD: begin
                if (!vid_slot) begin
                    vram_re   = 1'b1;
                    vram_addr = r_addr;
                    w_next    = S_WAIT;
                end
            end
            S_WAIT: begin
                if (w_lat_last) w_next = r_rwn ? S_DONE : S_MERGE;
            end
            S_MERGE: begin
                w_next = S_WR;
            end
            S_WR: begin
                if (!vid_slot) begin
                    vram_we   = 1'b1;
                    vram_addr = r_addr;
                    vram_d    = r_wbyte;
                    w_next    = S_DONE;
                end
            end
            S_DONE: begin
                done   = 1'b1;
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= S_IDLE;
            r_addr    <= '0;
            r_pix     <= 1'b0;
            r_rwn     <= 1'b0;
            r_wnib    <= 4'h0;
            r_q       <= 8'h00;
            r_wbyte   <= 8'h00;
            r_lat_cnt <= 3'd0;
            r_busy    <= 1'b0;
            r_overrun <= 1'b0;
            r_rdata   <= 8'h00;
        end else begin
            r_state <= w_next;

            // Inputs are frozen at capture so auto-increment stepping of
            // drba/pixa cannot disturb the access in flight.
            if (r_state == S_IDLE && w_req) begin
                r_addr <= drba;
                r_pix  <= pixa;
                r_rwn  <= bm_rwn;
                r_wnib <= bm_wdata[3:0];
                r_busy <= 1'b1;
            end

            // Requests are never queued; any request outside IDLE is lost.
            if (r_state != S_IDLE && w_req) r_overrun <= 1'b1;

            if (r_state == S_WAIT) begin
                if (w_lat_last) begin
                    r_lat_cnt <= 3'd0;
                    r_q       <= vram_q;
                    if (r_rwn) r_rdata <= w_rdata;
                end else begin
                    r_lat_cnt <= r_lat_cnt + 3'd1;
                end
            end

            if (r_state == S_MERGE)
                r_wbyte <= r_pix ? {r_q[7:4], r_wnib} : {r_wnib, r_q[3:0]};

            if (r_state == S_DONE) r_busy <= 1'b0;
        end
    end

    assign busy     = r_busy;
    assign overrun  = r_overrun;
    assign bm_rdata = r_rdata;

endmodule
